// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-bypass scoreboard.
// Entry fields are sized to the widest supported configuration so the struct is parameter-independent.
package fwd_pkg;

  localparam int unsigned FWD_RD_W   = 16;
  localparam int unsigned FWD_CNT_W  = 8;
  localparam int unsigned FWD_SEL_RF = 0;

  typedef struct packed {
    logic                 vld;
    logic [FWD_RD_W-1:0]  rd;
    logic [FWD_CNT_W-1:0] cnt;
  } fwd_entry_t;

  // Remaining-cycle count for a fresh issue: latency clamped to [1, max_lat], minus one.
  function automatic logic [FWD_CNT_W-1:0] fwd_lat_cnt(input logic [FWD_CNT_W-1:0] lat,
                                                       input logic [FWD_CNT_W-1:0] max_lat);
    logic [FWD_CNT_W-1:0] l;
    l = lat;
    if (l == '0) begin
      l = FWD_CNT_W'(1);
    end else if (l > max_lat) begin
      l = max_lat;
    end
    return l - FWD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Youngest-match priority encoder for one ID read port over the next-state scoreboard.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned SEL_W  = 3
) (
  input  fwd_entry_t [DEPTH-1:0] entries_i,
  input  logic [REG_AW-1:0]      rs_i,
  output logic [SEL_W-1:0]       sel_o,
  output logic                   not_ready_o
);

  // Scan oldest to youngest so the lowest-index match wins.
  always_comb begin
    sel_o       = SEL_W'(FWD_SEL_RF);
    not_ready_o = 1'b0;
    if (rs_i != '0) begin
      for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
        if (entries_i[s].vld && (entries_i[s].rd == FWD_RD_W'(rs_i))) begin
          sel_o       = SEL_W'(s + 1);
          not_ready_o = (entries_i[s].cnt != '0);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-bypass controller: latency scoreboard, per-port bypass selects and load-use stall.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned MAX_LAT = 4
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            issue_valid_i,
  input  logic [REG_AW-1:0]                               issue_rd_i,
  input  logic [$clog2(MAX_LAT+1)-1:0]                    issue_lat_i,
  input  logic [NUM_RD*REG_AW-1:0]                        id_rs_i,
  input  logic                                            flush_i,
  output logic [NUM_RD*$clog2(MAX_LAT+2)-1:0]             fwd_sel_o,
  output logic                                            stall_o,
  output logic [31:0]                                     stall_cnt_o
);

  localparam int unsigned DEPTH = MAX_LAT + 1;
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);
  localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);

  fwd_entry_t [DEPTH-1:0]   sb_q;
  fwd_entry_t [DEPTH-1:0]   sb_d;
  logic [NUM_RD*SEL_W-1:0]  fwd_sel_q;
  logic [NUM_RD*SEL_W-1:0]  fwd_sel_d;
  logic [SEL_W-1:0]         sel_c [NUM_RD];
  logic [NUM_RD-1:0]        not_ready_c;
  logic [LAT_W-1:0]         lat_unused_c;

  assign lat_unused_c = issue_lat_i;

  // Shift pipeline, aging each entry toward ready; new issue enters stage 0.
  always_comb begin
    sb_d        = '0;
    sb_d[0].vld = issue_valid_i && (issue_rd_i != '0);
    sb_d[0].rd  = FWD_RD_W'(issue_rd_i);
    sb_d[0].cnt = fwd_lat_cnt(FWD_CNT_W'(lat_unused_c), FWD_CNT_W'(MAX_LAT));
    for (int s = 1; s < int'(DEPTH); s++) begin
      sb_d[s] = sb_q[s-1];
      if (sb_q[s-1].cnt != '0) begin
        sb_d[s].cnt = sb_q[s-1].cnt - FWD_CNT_W'(1);
      end
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_port
    fwd_port_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_match (
      .entries_i   (sb_d),
      .rs_i        (id_rs_i[p*REG_AW +: REG_AW]),
      .sel_o       (sel_c[p]),
      .not_ready_o (not_ready_c[p])
    );
  end

  assign stall_o = (|not_ready_c) && !flush_i;

  // A stalled or squashed consumer leaves a bubble in EX, so it must not bypass.
  always_comb begin
    fwd_sel_d = '0;
    if (!stall_o && !flush_i) begin
      for (int p = 0; p < int'(NUM_RD); p++) begin
        fwd_sel_d[p*SEL_W +: SEL_W] = sel_c[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q      <= '0;
      fwd_sel_q <= '0;
    end else begin
      sb_q      <= sb_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign fwd_sel_o = fwd_sel_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomized bench for fwd_scoreboard against a producer-age reference model.
module tb_fwd_scoreboard;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_RD  = 2;
  localparam int unsigned MAX_LAT = 4;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned LAT_W   = 3;

  logic                      clk = 1'b0;
  logic                      rst_i = 1'b1;
  logic                      issue_valid_i = 1'b0;
  logic [REG_AW-1:0]         issue_rd_i = '0;
  logic [LAT_W-1:0]          issue_lat_i = '0;
  logic [NUM_RD*REG_AW-1:0]  id_rs_i = '0;
  logic                      flush_i = 1'b0;
  logic [NUM_RD*SEL_W-1:0]   fwd_sel_o;
  logic                      stall_o;
  logic [31:0]               stall_cnt_o;

  fwd_scoreboard #(
    .REG_AW  (REG_AW),
    .NUM_RD  (NUM_RD),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_lat_i   (issue_lat_i),
    .id_rs_i       (id_rs_i),
    .flush_i       (flush_i),
    .fwd_sel_o     (fwd_sel_o),
    .stall_o       (stall_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk = ~clk;

  // In-flight producer: destination, effective latency, issue cycle.
  typedef struct {
    int rd;
    int lat;
    int t;
  } prod_t;

  prod_t   pend[$];
  int      now = 0;
  int      n_checks = 0;
  int      n_errors = 0;
  longint  exp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, now, got, exp);
    end
  endtask

  function automatic int eff_lat(input int l);
    if (l == 0) return 1;
    if (l > int'(MAX_LAT)) return int'(MAX_LAT);
    return l;
  endfunction

  // Youngest producer of rs decides: select = age+1, not ready while age < lat-1.
  task automatic lookup(input int rs, output int sel, output bit nr);
    int best_age;
    best_age = 1000;
    sel = 0;
    nr  = 1'b0;
    if (rs != 0) begin
      foreach (pend[i]) begin
        int age;
        age = now - pend[i].t;
        if (pend[i].rd == rs && age <= int'(MAX_LAT) && age < best_age) begin
          best_age = age;
          sel      = age + 1;
          nr       = (age < pend[i].lat - 1);
        end
      end
    end
  endtask

  task automatic step(input bit v, input int rd, input int lat, input int rs0, input int rs1,
                      input bit fl, input bit r);
    int sel0, sel1;
    bit nr0, nr1, exp_stall;
    logic [63:0] exp_fsel;
    @(negedge clk);
    rst_i         = r;
    issue_valid_i = v;
    issue_rd_i    = REG_AW'(rd);
    issue_lat_i   = LAT_W'(lat);
    id_rs_i       = {REG_AW'(rs1), REG_AW'(rs0)};
    flush_i       = fl;
    if (!r && v && rd != 0) pend.push_back('{rd, eff_lat(lat), now});
    lookup(rs0, sel0, nr0);
    lookup(rs1, sel1, nr1);
    exp_stall = (nr0 || nr1) && !fl;
    #1;
    if (!r) check("stall", 64'(stall_o), 64'(exp_stall));
    exp_fsel = (r || exp_stall || fl) ? 64'd0 : 64'((sel1 << SEL_W) | sel0);
`ifdef FWD_STALL_CNT_EN
    if (r) exp_cnt = 0;
    else if (exp_stall && exp_cnt != 64'hFFFF_FFFF) exp_cnt++;
`endif
    @(posedge clk);
    #1;
    now++;
    if (r) begin
      pend.delete();
    end else begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (now - pend[i].t > int'(MAX_LAT)) pend.delete(i);
      end
    end
    check("fwd_sel", 64'(fwd_sel_o), exp_fsel);
    check("stall_cnt", 64'(stall_cnt_o), 64'(exp_cnt));
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // ALU result bypassed from stage 0
    step(1, 5, 1, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // two-cycle producer: one bubble then bypass from stage 1
    step(1, 7, 2, 0, 7, 0, 0);
    step(0, 0, 0, 0, 7, 0, 0);
    step(0, 0, 0, 0, 7, 0, 0);
    // back-to-back writers of the same register: youngest wins
    step(1, 3, 1, 0, 0, 0, 0);
    step(1, 3, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // r0 never tracked
    step(1, 0, 4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // four-cycle producer with consumer held in ID
    step(1, 9, 4, 9, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 9, 0, 0, 0);
    // reset drops in-flight producer
    step(1, 9, 4, 9, 0, 0, 0);
    step(0, 0, 0, 9, 0, 0, 1);
    step(0, 0, 0, 9, 0, 0, 0);
    step(0, 0, 0, 9, 0, 0, 0);
    // flush overrides a pending stall
    step(1, 4, 4, 4, 4, 1, 0);
    step(0, 0, 0, 4, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
